csr_access_ctrl: RTL and testbench

Sequencing controller in front of the CSR register file (combinational read, write on clk rising edge, 12-bit addresses truncated to the low CSR_ADDR_LEN bits inside the file). It turns Zicsr instructions from the execute stage into atomic read-modify-write sequences. It also arbitrates the single CSR port against the hardware trap-entry sequence, which writes mepc and mcause and fetches mtvec. It is the only master driving the register file's write and read ports.

---
 rtl/csr_access_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl
// Description : Sequencer between the execute stage and the CSR register file.
//               It turns Zicsr instructions into atomic read-modify-write
//               operations and arbitrates the single CSR port against the
//               hardware trap-entry sequence, which writes mepc and mcause
//               and fetches mtvec.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_ctrl #(
    parameter int          CSR_ADDR_LEN = 4,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MTVEC_ADDR   = 12'h305
) (
    input  logic        clk,
    input  logic        rst,
    // execute-stage request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_rs1_data,
    input  logic [4:0]  req_zimm,
    // response to writeback
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    // trap entry
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    output logic        trap_ack,
    output logic [31:0] trap_vector,
    output logic        busy,
    // register-file port
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [11:0] csr_raddr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata
);

    localparam logic [1:0] C_IDLE       = 2'd0;
    localparam logic [1:0] C_EXEC       = 2'd1;
    localparam logic [1:0] C_TRAP_EPC   = 2'd2;
    localparam logic [1:0] C_TRAP_CAUSE = 2'd3;

    // The attached file indexes with at most the full 12-bit CSR address.
    generate
        if (CSR_ADDR_LEN < 1 || CSR_ADDR_LEN > 12) begin : g_bad_addr_len
            $error("CSR_ADDR_LEN must be in 1..12");
        end
    endgenerate

    logic [1:0]  r_state;
    logic [2:0]  r_funct3;
    logic [11:0] r_addr;
    logic [31:0] r_operand;
    logic        r_zero_src;
    logic        r_illegal;
    logic [31:0] r_pc;
    logic [31:0] r_cause;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_illegal;
    logic        r_trap_ack;
    logic [31:0] r_trap_vector;

    logic        w_trap_take;
    logic        w_accept;
    logic        w_illegal_req;
    logic [31:0] w_operand_in;
    logic        w_exec_we;
    logic [31:0] w_new_value;
    logic [31:0] w_vector;

    // A trap wins arbitration in IDLE, except in its own ack cycle where the
    // requester has not yet had the chance to drop trap_valid.
    assign w_trap_take   = (r_state == C_IDLE) && trap_valid && !r_trap_ack;
    assign req_ready     = (r_state == C_IDLE) && !w_trap_take;
    assign w_accept      = req_valid && req_ready;
    assign w_illegal_req = (req_funct3 == 3'b000) || (req_funct3 == 3'b100) ||
                           (req_addr[11:8] != 4'h3);
    assign w_operand_in  = req_funct3[2] ? {27'b0, req_zimm} : req_rs1_data;

    // Set/clear forms with a zero source register or immediate must not write;
    // funct3[1] distinguishes set/clear from plain write among legal encodings.
    assign w_exec_we     = !r_illegal && !(r_funct3[1] && r_zero_src);
    assign w_vector      = csr_rdata & 32'hFFFF_FFFC;

    // Read-modify-write value computed from the live register-file read.
    always_comb begin
        w_new_value = r_operand;
        case (r_funct3[1:0])
            2'b10:   w_new_value = csr_rdata | r_operand;
            2'b11:   w_new_value = csr_rdata & ~r_operand;
            default: w_new_value = r_operand;
        endcase
    end

    // Register-file port: only one master, everything zero when idle.
    always_comb begin
        csr_we    = 1'b0;
        csr_waddr = 12'h000;
        csr_wdata = 32'h0;
        csr_raddr = 12'h000;
        case (r_state)
            C_EXEC: begin
                if (!r_illegal) begin
                    csr_raddr = r_addr;
                end
                if (w_exec_we) begin
                    csr_we    = 1'b1;
                    csr_waddr = r_addr;
                    csr_wdata = w_new_value;
                end
            end
            C_TRAP_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = MEPC_ADDR;
                csr_wdata = r_pc;
            end
            C_TRAP_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = MCAUSE_ADDR;
                csr_wdata = r_cause;
                csr_raddr = MTVEC_ADDR;
            end
            default: begin
                csr_we = 1'b0;
            end
        endcase
    end

    // Sequencer state, latched request/trap operands and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= C_IDLE;
            r_funct3       <= 3'b000;
            r_addr         <= 12'h000;
            r_operand      <= 32'h0;
            r_zero_src     <= 1'b0;
            r_illegal      <= 1'b0;
            r_pc           <= 32'h0;
            r_cause        <= 32'h0;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= 32'h0;
            r_resp_illegal <= 1'b0;
            r_trap_ack     <= 1'b0;
            r_trap_vector  <= 32'h0;
        end else begin
            r_resp_valid   <= 1'b0;
            r_resp_illegal <= 1'b0;
            r_trap_ack     <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (w_trap_take) begin
                        r_pc    <= trap_pc;
                        r_cause <= trap_cause;
                        r_state <= C_TRAP_EPC;
                    end else if (w_accept) begin
                        r_funct3   <= req_funct3;
                        r_addr     <= req_addr;
                        r_operand  <= w_operand_in;
                        r_zero_src <= (req_zimm == 5'd0);
                        r_illegal  <= w_illegal_req;
                        r_state    <= C_EXEC;
                    end
                end
                C_EXEC: begin
                    r_resp_valid   <= 1'b1;
                    r_resp_illegal <= r_illegal;
                    r_resp_rdata   <= r_illegal ? 32'h0 : csr_rdata;
                    r_state        <= C_IDLE;
                end
                C_TRAP_EPC: begin
                    r_state <= C_TRAP_CAUSE;
                end
                C_TRAP_CAUSE: begin
                    r_trap_ack    <= 1'b1;
                    r_trap_vector <= w_vector;
                    r_state       <= C_IDLE;
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_illegal = r_resp_illegal;
    assign trap_ack     = r_trap_ack;
    assign trap_vector  = r_trap_vector;
    assign busy         = (r_state != C_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_ctrl
// Description : Self-checking bench for csr_access_ctrl with a CSR file
//               stand-in and an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_zimm;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        trap_ack;
    logic [31:0] trap_vector;
    logic        busy;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [11:0] csr_raddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    csr_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_rs1_data (req_rs1_data),
        .req_zimm     (req_zimm),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_illegal (resp_illegal),
        .trap_valid   (trap_valid),
        .trap_pc      (trap_pc),
        .trap_cause   (trap_cause),
        .trap_ack     (trap_ack),
        .trap_vector  (trap_vector),
        .busy         (busy),
        .csr_we       (csr_we),
        .csr_waddr    (csr_waddr),
        .csr_raddr    (csr_raddr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata)
    );

    always #5 clk = ~clk;

    // CSR file stand-in (full 12-bit addressing) and the reference contents.
    bit [31:0]   rf  [4096];
    bit [31:0]   mdl [4096];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'h0;
    logic [31:0] pl_data = 32'h0;

    assign csr_rdata = rf[csr_raddr];

    // Backdoor preload while idle, otherwise the DUT's write port.
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (csr_we) rf[csr_waddr] <= csr_wdata;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        mdl[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] f, input logic [11:0] a,
                             input logic [31:0] rs1, input logic [4:0] z);
        req_valid = 1'b1; req_funct3 = f; req_addr = a; req_rs1_data = rs1; req_zimm = z;
    endtask

    // Instruction-level semantics: returns the old value seen by rd and
    // updates the reference contents, given the cycle after accept.
    task automatic csr_finish(input logic [2:0] f, input logic [11:0] a,
                              input logic [31:0] rs1, input logic [4:0] z);
        bit          legal;
        bit          wr;
        logic [31:0] old;
        logic [31:0] opnd;
        logic [31:0] nv;
        legal = !(f == 3'b000 || f == 3'b100) && (a[11:8] == 4'h3);
        old   = mdl[a];
        opnd  = (f inside {3'b101, 3'b110, 3'b111}) ? {27'b0, z} : rs1;
        case (f)
            3'b001, 3'b101: nv = opnd;
            3'b010, 3'b110: nv = old | opnd;
            3'b011, 3'b111: nv = old & ~opnd;
            default:        nv = old;
        endcase
        wr = legal && !((f inside {3'b010, 3'b011, 3'b110, 3'b111}) && z == 5'd0);

        @(negedge clk);
        req_valid = 1'b0; trap_valid = 1'b0;
        req_rs1_data = $urandom; req_zimm = 5'($urandom);
        #1;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_we", 32'(csr_we), 32'(wr));
        chk("exec_resp_early", 32'(resp_valid), 32'd0);
        if (wr) begin
            chk("exec_waddr", 32'(csr_waddr), 32'(a));
            chk("exec_wdata", csr_wdata, nv);
        end else begin
            chk("exec_wdata_idle", csr_wdata, 32'd0);
        end

        @(negedge clk);
        #1;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_rdata", resp_rdata, legal ? old : 32'd0);
        chk("resp_illegal", 32'(resp_illegal), 32'(!legal));
        chk("resp_trap_ack", 32'(trap_ack), 32'd0);
        chk("resp_busy", 32'(busy), 32'd0);
        if (wr) mdl[a] = nv;
        chk("rf_content", rf[a], mdl[a]);
    endtask

    task automatic csr_op(input logic [2:0] f, input logic [11:0] a,
                          input logic [31:0] rs1, input logic [4:0] z);
        @(negedge clk);
        drive_req(f, a, rs1, z);
        #1;
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_we", 32'(csr_we), 32'd0);
        csr_finish(f, a, rs1, z);
    endtask

    // Trap entry; optionally a CSR request is raised in the same cycle and
    // must be taken only once the trap is acknowledged.
    task automatic trap_seq(input logic [31:0] pc, input logic [31:0] cause, input bit with_req,
                            input logic [2:0] f, input logic [11:0] a,
                            input logic [31:0] rs1, input logic [4:0] z);
        @(negedge clk);
        trap_valid = 1'b1; trap_pc = pc; trap_cause = cause;
        if (with_req) drive_req(f, a, rs1, z);
        #1;
        chk("trap_T_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        trap_pc = $urandom; trap_cause = $urandom;
        #1;
        chk("trap_epc_we", 32'(csr_we), 32'd1);
        chk("trap_epc_addr", 32'(csr_waddr), 32'h341);
        chk("trap_epc_data", csr_wdata, pc);
        chk("trap_epc_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("trap_cause_we", 32'(csr_we), 32'd1);
        chk("trap_cause_addr", 32'(csr_waddr), 32'h342);
        chk("trap_cause_data", csr_wdata, cause);
        chk("trap_cause_raddr", 32'(csr_raddr), 32'h305);
        chk("trap_cause_ack_early", 32'(trap_ack), 32'd0);
        mdl[12'h341] = pc;
        mdl[12'h342] = cause;
        @(negedge clk);
        #1;
        chk("trap_ack", 32'(trap_ack), 32'd1);
        chk("trap_vector", trap_vector, mdl[12'h305] & 32'hFFFF_FFFC);
        chk("trap_ack_resp", 32'(resp_valid), 32'd0);
        chk("trap_ack_busy", 32'(busy), 32'd0);
        chk("trap_ack_ready", 32'(req_ready), 32'd1);
        chk("rf_mepc", rf[12'h341], pc);
        chk("rf_mcause", rf[12'h342], cause);
        if (with_req) begin
            csr_finish(f, a, rs1, z);
        end else begin
            @(negedge clk);
            trap_valid = 1'b0;
            #1;
            chk("trap_ack_pulse", 32'(trap_ack), 32'd0);
            chk("trap_vector_hold", trap_vector, mdl[12'h305] & 32'hFFFF_FFFC);
            chk("trap_after_busy", 32'(busy), 32'd0);
        end
    endtask

    logic [2:0]  rf3;
    logic [11:0] ra;
    logic [31:0] rrs;
    logic [4:0]  rz;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_funct3 = 3'b0; req_addr = 12'h0; req_rs1_data = 32'h0; req_zimm = 5'h0;
        trap_valid = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(csr_we), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_trap_ack", 32'(trap_ack), 32'd0);
        chk("rst_trap_vector", trap_vector, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed instruction sequence.
        preload(12'h340, 32'h12);
        csr_op(3'b001, 12'h340, 32'hDEADBEEF, 5'd1);
        preload(12'h300, 32'h00F);
        csr_op(3'b010, 12'h300, 32'h0F0, 5'd3);
        csr_op(3'b011, 12'h300, 32'h003, 5'd4);
        csr_op(3'b110, 12'h300, 32'hFFFF_FFFF, 5'd0);
        csr_op(3'b001, 12'h7C0, 32'h5555_AAAA, 5'd7);
        csr_op(3'b100, 12'h300, 32'h1234_5678, 5'd9);
        csr_op(3'b101, 12'h340, 32'h0, 5'd0);

        // Trap entry, then trap colliding with a request.
        preload(12'h305, 32'h1003);
        trap_seq(32'h80, 32'hB, 1'b0, 3'b000, 12'h0, 32'h0, 5'd0);
        trap_seq(32'h1234, 32'h8000_0007, 1'b1, 3'b010, 12'h300, 32'hF000_0000, 5'd2);

        // Asynchronous reset in the middle of trap entry.
        @(negedge clk);
        trap_valid = 1'b1; trap_pc = 32'hCAFE_0000; trap_cause = 32'h3;
        @(negedge clk);
        #1;
        chk("rst_mid_pre_we", 32'(csr_we), 32'd1);
        #1;
        rst = 1'b1;
        trap_valid = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_we", 32'(csr_we), 32'd0);
        chk("rst_mid_waddr", 32'(csr_waddr), 32'd0);
        chk("rst_mid_wdata", csr_wdata, 32'd0);
        chk("rst_mid_raddr", 32'(csr_raddr), 32'd0);
        chk("rst_mid_vector", trap_vector, 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_mid_no_ack", 32'(trap_ack), 32'd0);
        end
        chk("rst_mid_mcause", rf[12'h342], mdl[12'h342]);
        chk("rst_mid_mepc", rf[12'h341], mdl[12'h341]);

        // Randomized mix of instructions and traps.
        for (int i = 0; i < 60; i++) begin
            rf3 = 3'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : {4'h3, 8'($urandom_range(0, 7))};
            rrs = $urandom;
            rz  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                trap_seq($urandom, $urandom, 1'($urandom_range(0, 1)), rf3, ra, rrs, rz);
            end else begin
                csr_op(rf3, ra, rrs, rz);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
